// File: rtl/isp_src_pkg.sv
// Shared types for the ISP raster source: FSM state encoding and the
// read-to-beat latency of the frame-buffer path.
package isp_src_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HBLANK = 2'd2,
        DRAIN  = 2'd3
    } src_state_e;

    // One cycle in the memory plus one in the output register.
    localparam int RD_LAT = 2;

endpackage

// File: rtl/isp_frame_src_if.sv
// Frame-buffer read port plus outgoing pixel stream of the raster source.
// Handshake: no backpressure; a read issues whenever mem_rd_en is high, and
// every pixel_data_out_vld beat is taken by the consumer unconditionally.
interface isp_frame_src_if #(
    parameter int DW = 16,
    parameter int AW = 20
);
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [DW-1:0] mem_rd_data;
    logic [DW-1:0] pixel_data_out;
    logic          pixel_data_out_vld;
    logic          line_end;

    modport src (
        output mem_rd_en, mem_rd_addr, pixel_data_out, pixel_data_out_vld, line_end,
        input  mem_rd_data
    );

    modport sink (
        input  mem_rd_en, mem_rd_addr, pixel_data_out, pixel_data_out_vld, line_end,
        output mem_rd_data
    );
endinterface

// File: rtl/isp_src_vld_pipe.sv
// Two-stage delay of the read tag {last, line_end, vld}; bit 0 is the valid.
// A synchronous flush empties both stages so an aborted frame emits nothing more.
module isp_src_vld_pipe #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         d1_vld,
    output logic [W-1:0] dout
);
    logic [W-1:0] stg1;
    logic [W-1:0] stg2;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stg1 <= '0;
            stg2 <= '0;
        end else if (flush) begin
            stg1 <= '0;
            stg2 <= '0;
        end else begin
            stg1 <= din;
            stg2 <= stg1;
        end
    end

    assign d1_vld = stg1[0];
    assign dout   = stg2;
endmodule

// File: rtl/isp_frame_src.sv
// Raster pixel source: reads an H x V frame from a synchronous frame buffer in
// raster order and streams it out with HB idle cycles between lines.
module isp_frame_src
    import isp_src_pkg::*;
#(
    parameter int DW = 16,
    parameter int H  = 1280,
    parameter int V  = 720,
    parameter int HW = 11,
    parameter int VW = 10,
    parameter int AW = 20,
    parameter int HB = 16,
    parameter int BW = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              src_en,
    input  logic              frame_start,
    isp_frame_src_if.src      px,
    output logic              frame_done,
    output logic              busy,
    output src_state_e        fsm_state
);
    localparam logic [HW-1:0] H_LAST  = HW'(H - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V - 1);
    localparam logic [BW-1:0] HB_LAST = BW'((HB > 0) ? HB - 1 : 0);

    src_state_e    state;
    src_state_e    state_nxt;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [BW-1:0] blank_cnt;
    logic [AW-1:0] addr;
    logic          rd_en_q;
    logic          done_q;
    logic [DW-1:0] data_q;
    logic          abort;
    logic          line_last;
    logic          frame_last;
    logic          d1_vld;
    logic [2:0]    pipe_in;
    logic [2:0]    pipe_out;

    assign abort      = (state != IDLE) && !src_en;
    assign line_last  = (h_cnt == H_LAST);
    assign frame_last = line_last && (v_cnt == V_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (src_en && frame_start) state_nxt = ACTIVE;
            ACTIVE: begin
                if (frame_last)              state_nxt = DRAIN;
                else if (line_last && HB != 0) state_nxt = HBLANK;
            end
            HBLANK: if (blank_cnt == HB_LAST) state_nxt = ACTIVE;
            DRAIN:  if (done_q) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Counters describe the read issued in the current ACTIVE cycle; they sit
    // at zero outside a frame so a new frame always starts from address 0.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            blank_cnt <= '0;
            addr      <= '0;
        end else if (abort || state == IDLE) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            blank_cnt <= '0;
            addr      <= '0;
        end else if (state == ACTIVE) begin
            blank_cnt <= '0;
            addr      <= frame_last ? '0 : addr + AW'(1);
            if (line_last) begin
                h_cnt <= '0;
                v_cnt <= frame_last ? '0 : v_cnt + VW'(1);
            end else begin
                h_cnt <= h_cnt + HW'(1);
            end
        end else if (state == HBLANK) begin
            blank_cnt <= blank_cnt + BW'(1);
        end
    end

    assign pipe_in = {rd_en_q && frame_last, rd_en_q && line_last, rd_en_q};

    isp_src_vld_pipe #(.W(3)) u_vld_pipe (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (abort),
        .din    (pipe_in),
        .d1_vld (d1_vld),
        .dout   (pipe_out)
    );

    // done_q rises the cycle after the frame's last beat leaves the pipe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            rd_en_q <= (state_nxt == ACTIVE);
            done_q  <= !abort && pipe_out[2];
            if (d1_vld && !abort) data_q <= px.mem_rd_data;
        end
    end

    assign px.mem_rd_en          = rd_en_q;
    assign px.mem_rd_addr        = addr;
    assign px.pixel_data_out     = data_q;
    assign px.pixel_data_out_vld = pipe_out[0];
    assign px.line_end           = pipe_out[1];
    assign frame_done            = done_q;
    assign busy                  = (state != IDLE);
    assign fsm_state             = state;
endmodule

// File: tb/tb_isp_frame_src.sv
// Bench for isp_frame_src: two instances (HB=2 and HB=0) share one stimulus
// stream and are checked every cycle against a raster-schedule reference model.
module tb_isp_frame_src;
    import isp_src_pkg::*;

    localparam int DW = 16;
    localparam int AW = 20;
    localparam int H  = 4;
    localparam int V  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic src_en = 1'b0;
    logic frame_start = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUTs and memory models ----------------
    isp_frame_src_if #(.DW(DW), .AW(AW)) if_a ();
    isp_frame_src_if #(.DW(DW), .AW(AW)) if_b ();
    logic       done_a, done_b, busy_a, busy_b;
    src_state_e st_a, st_b;

    isp_frame_src #(.DW(DW), .H(H), .V(V), .HW(3), .VW(2), .AW(AW), .HB(2), .BW(2)) dut_a (
        .clk(clk), .rstn(rstn), .src_en(src_en), .frame_start(frame_start),
        .px(if_a.src), .frame_done(done_a), .busy(busy_a), .fsm_state(st_a)
    );

    isp_frame_src #(.DW(DW), .H(H), .V(V), .HW(3), .VW(2), .AW(AW), .HB(0), .BW(2)) dut_b (
        .clk(clk), .rstn(rstn), .src_en(src_en), .frame_start(frame_start),
        .px(if_b.src), .frame_done(done_b), .busy(busy_b), .fsm_state(st_b)
    );

    // Frame buffer contents: data = address, one cycle read latency.
    always @(posedge clk) begin
        if (if_a.mem_rd_en) if_a.mem_rd_data <= DW'(if_a.mem_rd_addr);
        if (if_b.mem_rd_en) if_b.mem_rd_data <= DW'(if_b.mem_rd_addr);
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];

    function automatic int q_size(input int i);
        return (i == 0) ? exp_q_a.size() : exp_q_b.size();
    endfunction

    task automatic q_clear(input int i);
        if (i == 0) exp_q_a.delete();
        else        exp_q_b.delete();
    endtask

    task automatic q_push(input int i, input logic [DW-1:0] v);
        if (i == 0) exp_q_a.push_back(v);
        else        exp_q_b.push_back(v);
    endtask

    function automatic logic [DW-1:0] q_pop(input int i);
        if (i == 0) return exp_q_a.pop_front();
        return exp_q_b.pop_front();
    endfunction

    // ---------------- reference model ----------------
    // A frame accepted in cycle c0 issues pixel (v,h) in cycle c0+1+v*(H+hb)+h,
    // its beat RD_LAT cycles later, and frame_done one cycle after the last beat.
    bit            act[2];
    int            c0[2];
    logic [DW-1:0] last_data[2];
    int            first_done[2];

    logic          o_rd[2], o_vld[2], o_le[2], o_done[2], o_busy[2], o_idle[2];
    logic [AW-1:0] o_addr[2];
    logic [DW-1:0] o_data[2];

    task automatic model_step(input int i, input int hb);
        int p, l, k, kb;
        bit e_rd, e_vld, e_le, e_done, e_busy;
        string s;
        s = (i == 0) ? "a" : "b";
        p = H + hb;
        l = V * p - hb;
        if (!rstn) begin
            check({"rst_rd_", s},   32'(o_rd[i]),   0);
            check({"rst_vld_", s},  32'(o_vld[i]),  0);
            check({"rst_le_", s},   32'(o_le[i]),   0);
            check({"rst_done_", s}, 32'(o_done[i]), 0);
            check({"rst_busy_", s}, 32'(o_busy[i]), 0);
            check({"rst_addr_", s}, 32'(o_addr[i]), 0);
            check({"rst_data_", s}, 32'(o_data[i]), 0);
            act[i] = 1'b0;
            last_data[i] = '0;
            q_clear(i);
            return;
        end
        k  = cyc - c0[i] - 1;
        kb = k - RD_LAT;
        e_rd   = act[i] && k >= 0 && k < l && (k % p) < H;
        e_vld  = act[i] && kb >= 0 && kb < l && (kb % p) < H;
        e_le   = e_vld && (kb % p) == H - 1;
        e_done = act[i] && k == l + RD_LAT;
        e_busy = act[i];

        check({"rd_en_", s}, 32'(o_rd[i]), 32'(e_rd));
        if (e_rd) check({"rd_addr_", s}, 32'(o_addr[i]), 32'((k / p) * H + (k % p)));
        check({"vld_", s},      32'(o_vld[i]),  32'(e_vld));
        check({"line_end_", s}, 32'(o_le[i]),   32'(e_le));
        check({"done_", s},     32'(o_done[i]), 32'(e_done));
        check({"busy_", s},     32'(o_busy[i]), 32'(e_busy));
        check({"idle_", s},     32'(o_idle[i]), 32'(!e_busy));
        if (e_vld) begin
            if (q_size(i) == 0) check({"sb_underrun_", s}, 0, 1);
            else last_data[i] = q_pop(i);
        end
        check({"data_", s}, 32'(o_data[i]), 32'(last_data[i]));

        if (e_done) begin
            check({"sb_left_", s}, 32'(q_size(i)), 0);
            act[i] = 1'b0;
        end
        if (act[i] && !src_en) begin
            act[i] = 1'b0;
            q_clear(i);
        end else if (!e_busy && src_en && frame_start) begin
            act[i] = 1'b1;
            c0[i]  = cyc;
            q_clear(i);
            for (int n = 0; n < H * V; n++) q_push(i, DW'(n));
        end
    endtask

    always @(negedge clk) begin
        o_rd[0] = if_a.mem_rd_en;   o_rd[1] = if_b.mem_rd_en;
        o_addr[0] = if_a.mem_rd_addr; o_addr[1] = if_b.mem_rd_addr;
        o_vld[0] = if_a.pixel_data_out_vld; o_vld[1] = if_b.pixel_data_out_vld;
        o_le[0] = if_a.line_end;    o_le[1] = if_b.line_end;
        o_data[0] = if_a.pixel_data_out; o_data[1] = if_b.pixel_data_out;
        o_done[0] = done_a;         o_done[1] = done_b;
        o_busy[0] = busy_a;         o_busy[1] = busy_b;
        o_idle[0] = (st_a == IDLE); o_idle[1] = (st_b == IDLE);
        if (done_a && first_done[0] < 0) first_done[0] = cyc;
        if (done_b && first_done[1] < 0) first_done[1] = cyc;
        model_step(0, 2);
        model_step(1, 0);
    end

    // ---------------- driver ----------------
    task automatic drive(input bit fs, input bit en, input bit rn);
        @(posedge clk);
        #1;
        frame_start = fs;
        src_en      = en;
        rstn        = rn;
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) drive(1'b0, 1'b1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    int s0;
    int en_hold;
    int rst_hold;

    initial begin
        first_done[0] = -1;
        first_done[1] = -1;
        act[0] = 1'b0; act[1] = 1'b0;
        c0[0] = 0; c0[1] = 0;
        last_data[0] = '0; last_data[1] = '0;

        // Reset, then release with the block enabled.
        for (int j = 0; j < 3; j++) drive(1'b0, 1'b0, 1'b0);
        idle_cycles(3);

        // Basic frame; pulses at relative 5 and 19 land while busy, 20 starts anew.
        drive(1'b1, 1'b1, 1'b1);
        s0 = cyc;
        for (int r = 1; r <= 21; r++) drive(r == 5 || r == 19 || r == 20, 1'b1, 1'b1);
        idle_cycles(25);
        check("first_done_rel_a", 32'(first_done[0] - s0), 19);
        check("first_done_rel_b", 32'(first_done[1] - s0), 15);

        // Enable dropped at relative cycle 8, then a clean restart.
        drive(1'b1, 1'b1, 1'b1);
        for (int r = 1; r <= 12; r++) drive(1'b0, !(r >= 8 && r <= 9), 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        idle_cycles(24);

        // Asynchronous reset at relative cycle 10, then a full frame.
        drive(1'b1, 1'b1, 1'b1);
        for (int r = 1; r <= 12; r++) drive(1'b0, 1'b1, !(r >= 10 && r <= 11));
        drive(1'b1, 1'b1, 1'b1);
        idle_cycles(24);

        // frame_start while disabled.
        for (int j = 0; j < 5; j++) drive(1'b1, 1'b0, 1'b1);
        idle_cycles(3);

        // Randomized traffic with occasional aborts and resets.
        en_hold  = 0;
        rst_hold = 0;
        for (int j = 0; j < 3000; j++) begin
            if (en_hold > 0) en_hold--;
            else if ($urandom_range(0, 79) == 0) en_hold = $urandom_range(1, 4);
            if (rst_hold > 0) rst_hold--;
            else if ($urandom_range(0, 399) == 0) rst_hold = $urandom_range(1, 3);
            drive($urandom_range(0, 5) == 0, en_hold == 0, rst_hold == 0);
        end
        idle_cycles(30);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/isp_frame_src.md
Name: isp_frame_src

Overview:
- Raster pixel-stream transmitter: the source end of the ISP serial pixel interface (data + vld, H×V raster, no backpressure) that filter stages such as the AAF consume.
- On a frame_start pulse it reads one H×V frame from a synchronous frame-buffer read port in raster order.
- It emits the pixels on pixel_data_out/pixel_data_out_vld, inserts HB idle cycles between lines, and pulses frame_done after the last pixel.
- Sits between the frame buffer and the first ISP filter stage.

Parameters:
DW, 16, pixel data width
H, 1280, pixels per line
V, 720, lines per frame
HW, 11, h counter width (≥ clog2(H))
VW, 10, v counter width (≥ clog2(V))
AW, 20, frame-buffer address width (≥ clog2(H*V))
HB, 16, idle cycles inserted between consecutive lines (0 allowed)
BW, 8, blank counter width (≥ clog2(HB+1))

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
src_en  in  1  block enable; low aborts any frame in progress
frame_start  in  1  one-cycle start request, sampled only in IDLE
mem_rd_en  out  1  frame-buffer read strobe (registered)
mem_rd_addr  out  AW  linear read address v*H+h (registered)
mem_rd_data  in  DW  read data, valid the cycle after the memory samples mem_rd_en
pixel_data_out  out  DW  pixel data (registered)
pixel_data_out_vld  out  1  pixel valid, one beat per pixel
line_end  out  1  high with the vld beat of pixel h=H-1 of each line
frame_done  out  1  one-cycle pulse after the final pixel beat
busy  out  1  high from frame acceptance through the frame_done cycle

Behaviour:
- Reset: all outputs 0; FSM=IDLE; h_cnt, v_cnt, blank_cnt and address cleared; vld pipeline cleared. Reset mid-frame drops the frame immediately with no frame_done.
- FSM states: IDLE, ACTIVE, HBLANK, DRAIN.
- IDLE:
  - src_en&&frame_start → ACTIVE; h=v=0; addr=0; busy=1.
  - frame_start with src_en=0 is ignored.
- ACTIVE, one read per cycle:
  - mem_rd_en=1, mem_rd_addr=current addr; addr+1 and h+1 each cycle.
  - At h==H-1: h←0.
    - v==V-1 → DRAIN.
    - else v+1, then HB==0 → stay ACTIVE (back-to-back lines), else HBLANK with blank_cnt=0.
- HBLANK: mem_rd_en=0; after exactly HB cycles → ACTIVE.
- DRAIN:
  - mem_rd_en=0; wait until the 2-stage vld pipeline is empty.
  - Then assert frame_done for 1 cycle and go to IDLE; busy drops the cycle after frame_done.
- Latency:
  - First mem_rd_en is visible the cycle after frame_start is sampled.
  - pixel_data_out_vld follows mem_rd_en by exactly 2 cycles (memory register plus output register).
  - line_end and the h==H-1 tag travel down the same 2-stage pipeline.
  - pixel_data_out holds its last value when vld=0.
- Output stream: exactly H*V beats per frame, each line is H consecutive beats, HB gap cycles between lines, no gap inside a line.
- frame_done is asserted the cycle after the last beat (pixel H-1, V-1).
- frame_start is ignored while busy, including the frame_done cycle; a new frame may start the following cycle.
- src_en deassert in any non-IDLE state:
  - Next cycle: FSM=IDLE, mem_rd_en=0, vld pipeline flushed (vld=0), counters cleared, busy=0, no frame_done.
  - Beats already on the output register before the abort are not retracted.
- Address: never exceeds H*V-1; no wrap within a frame; reset to 0 on each accepted frame_start.

Decomposition:
- Package isp_src_pkg: FSM state enum (IDLE, ACTIVE, HBLANK, DRAIN) and the read-latency constant RD_LAT=2 shared with the bench memory model.
- One sub-module, isp_src_vld_pipe: parameterised 2-stage delay of {vld, line_end, last} with a synchronous flush input.
- The FSM and counters stay in the top module.

Test Plan (H=4, V=3, HB=2, memory model returns data=addr, 1-cycle latency):
- Basic frame: frame_start at cycle 0 →
  - mem_rd_en high cycles 1–4, 7–10, 13–16.
  - vld beats with data 0..11 at cycles 3–6, 9–12, 15–18.
  - line_end at cycles 6, 12, 18; frame_done at cycle 19; busy high cycles 1–19.
- HB=0 variant → 12 consecutive vld beats at cycles 3–14; frame_done at cycle 15.
- frame_start pulsed at cycles 5 and 19 of a running frame → ignored; frame_start at cycle 20 → new frame, first beat (data 0) at cycle 23.
- src_en deasserted at cycle 8 → from cycle 9 on: vld=0, mem_rd_en=0, busy=0; frame_done never asserted; a later frame_start restarts from addr 0.
- rstn asserted at cycle 10 mid-line → all outputs 0 immediately; after release a frame_start yields a full clean 12-beat frame.
- frame_start with src_en=0 → no mem_rd_en, no vld, busy stays 0.
